// File: rtl/vga_reg_sched.sv
// ============================================================================
// Module  : vga_reg_sched
// Brief   : Captures up to four 16-bit requester values and schedules one of
//           them per frame onto a register-drawer overlay.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_reg_sched #(
    parameter int unsigned FRAMES_PER_SLOT = 60,
    parameter logic [9:0]  X_BASE          = 10'd16,
    parameter logic [9:0]  Y_BASE          = 10'd16
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [25:0] strRGB_i,
    input  logic [3:0]  req,
    input  logic [63:0] data_i,
    input  logic        auto_i,
    input  logic [1:0]  sel_i,
    input  logic        freeze_i,
    input  logic [2:0]  zoom_i,
    output logic [3:0]  ack,
    output logic [15:0] register_o,
    output logic [9:0]  x_pos_o,
    output logic [9:0]  y_pos_o,
    output logic [2:0]  zoom_o,
    output logic [1:0]  slot_o,
    output logic        frame_tick
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_EMPTY  = 2'd2;

    localparam logic [7:0] C_CNT_LAST = 8'(FRAMES_PER_SLOT - 1);

    logic        r_vs_q;
    logic        r_armed;
    logic [15:0] r_shadow [4];
    logic [3:0]  r_valid;
    logic [1:0]  r_rr_ptr;
    logic [7:0]  r_frame_cnt;
    logic [1:0]  r_state;

    logic        w_grant_vld;
    logic [1:0]  w_grant_idx;
    logic [1:0]  w_arb_cand;
    logic [1:0]  w_next_valid;
    logic [1:0]  w_first_valid;
    logic [1:0]  w_scan;
    logic        w_entry;
    logic        w_run;
    logic        w_load;
    logic [1:0]  w_new_slot;
    logic [7:0]  w_new_cnt;
    logic [9:0]  w_y_next;
    logic        w_unused_rgb;

    assign w_unused_rgb = ^{strRGB_i[25:2], strRGB_i[0]};

    // No new grant while any ack is outstanding, so acks are always separated.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_arb_cand  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_arb_cand = r_rr_ptr + 2'(i);
            if (!w_grant_vld && req[w_arb_cand] && (ack == 4'd0)) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_arb_cand;
            end
        end
    end

    // w_next_valid skips the current slot; w_first_valid may pick it.
    always_comb begin
        w_next_valid  = slot_o;
        w_first_valid = slot_o;
        w_scan        = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            w_scan = slot_o + 2'(i);
            if (r_valid[w_scan]) begin
                w_next_valid = w_scan;
            end
        end
        for (int i = 3; i >= 0; i--) begin
            w_scan = slot_o + 2'(i);
            if (r_valid[w_scan]) begin
                w_first_valid = w_scan;
            end
        end
    end

    assign w_entry = frame_tick && (r_state == ST_EMPTY) && (|r_valid);
    assign w_run   = frame_tick && !freeze_i &&
                     ((r_state == ST_RUN) || (r_state == ST_FREEZE));
    assign w_load  = w_entry || w_run;

    always_comb begin
        w_new_slot = slot_o;
        w_new_cnt  = r_frame_cnt;
        if (w_entry) begin
            w_new_slot = auto_i ? w_first_valid : sel_i;
            w_new_cnt  = 8'd0;
        end else if (!auto_i) begin
            w_new_slot = sel_i;
            w_new_cnt  = 8'd0;
        end else if (r_frame_cnt == C_CNT_LAST) begin
            w_new_slot = w_next_valid;
            w_new_cnt  = 8'd0;
        end else begin
            w_new_cnt  = r_frame_cnt + 8'd1;
        end
    end

    assign w_y_next = Y_BASE + ({8'd0, w_new_slot} << (4'd3 + {1'b0, zoom_i}));

    // Frame start detection; r_armed masks a VS already high at reset release.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_vs_q     <= 1'b0;
            r_armed    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_vs_q     <= strRGB_i[1];
            r_armed    <= 1'b1;
            frame_tick <= r_armed && !r_vs_q && strRGB_i[1];
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 16'd0;
            end
            r_valid  <= 4'd0;
            r_rr_ptr <= 2'd0;
            ack      <= 4'd0;
        end else begin
            ack <= 4'd0;
            if (w_grant_vld) begin
                r_shadow[w_grant_idx] <= data_i[16*w_grant_idx +: 16];
                r_valid[w_grant_idx]  <= 1'b1;
                ack[w_grant_idx]      <= 1'b1;
                r_rr_ptr              <= w_grant_idx + 2'd1;
            end
        end
    end

    // Display reads pre-capture shadow/valid, so a same-cycle capture waits a frame.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_frame_cnt <= 8'd0;
            slot_o      <= 2'd0;
            register_o  <= 16'd0;
            zoom_o      <= 3'd0;
            x_pos_o     <= X_BASE;
            y_pos_o     <= Y_BASE;
        end else if (frame_tick) begin
            case (r_state)
                ST_EMPTY:  if (|r_valid) r_state <= ST_RUN;
                ST_RUN:    if (freeze_i) r_state <= ST_FREEZE;
                ST_FREEZE: if (!freeze_i) r_state <= ST_RUN;
                default:   r_state <= ST_EMPTY;
            endcase
            if (w_load) begin
                r_frame_cnt <= w_new_cnt;
                slot_o      <= w_new_slot;
                register_o  <= r_shadow[w_new_slot];
                zoom_o      <= zoom_i;
                x_pos_o     <= X_BASE;
                y_pos_o     <= w_y_next;
            end
        end
    end

endmodule

`default_nettype wire
